// File: rtl/dff_monitor.sv
// Runtime checker for a single flip-flop: samples d as the expected value and compares it with q one edge later.
// Optional build macro DFF_MON_QB_CHECK_EN additionally checks that qb is the complement of q.
//
// state | meaning
// IDLE  | monitoring off, no compare
// ARM   | exp being primed with a valid sample, no compare
// CHECK | q compared against exp every edge while mon_en is high
// SAT   | a counter hit all-ones; compares stop until clr or rst
module dff_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             q,
    input  logic             qb,
    input  logic             mon_en,
    input  logic             clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        SAT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_nxt;
    logic             exp_q;
    logic             mismatch;
    logic             do_cmp;
    logic [CNT_W-1:0] pass_nxt;
    logic [CNT_W-1:0] err_nxt;

`ifdef DFF_MON_QB_CHECK_EN
    // A q fault and a qb fault in the same cycle still count as one mismatch.
    assign mismatch = (q != exp_q) || (qb == q);
`else
    logic qb_unused;
    assign qb_unused = qb;
    assign mismatch  = (q != exp_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_nxt = mon_en ? ARM : IDLE;
                ARM:     state_nxt = mon_en ? CHECK : IDLE;
                CHECK: begin
                    if (!mon_en) begin
                        state_nxt = IDLE;
                    end else if (pass_nxt == CNT_MAX || err_nxt == CNT_MAX) begin
                        state_nxt = SAT;
                    end
                end
                SAT:     state_nxt = SAT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A clr on the compare edge discards that compare.
    always_comb begin
        do_cmp = 1'b0;
        if (state_q == CHECK && mon_en && !clr) begin
            do_cmp = 1'b1;
        end
    end

    always_comb begin
        pass_nxt = pass_cnt;
        err_nxt  = err_cnt;
        if (do_cmp && !mismatch && pass_cnt != CNT_MAX) begin
            pass_nxt = pass_cnt + CNT_W'(1);
        end
        if (do_cmp && mismatch && err_cnt != CNT_MAX) begin
            err_nxt = err_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= 1'b0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            exp_q <= d;
            if (clr) begin
                pass_cnt   <= '0;
                err_cnt    <= '0;
                err_pulse  <= 1'b0;
                err_sticky <= 1'b0;
            end else begin
                pass_cnt  <= pass_nxt;
                err_cnt   <= err_nxt;
                err_pulse <= do_cmp && mismatch;
                if (do_cmp && mismatch) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_dff_monitor.sv
// Directed bench for dff_monitor: a 16-bit instance for function checks and a 4-bit instance for saturation.
module tb_dff_monitor;

    logic        clk;
    logic        rst;
    logic        d;
    logic        q;
    logic        qb;
    logic        mon_en;
    logic        clr;
    logic        q_ff;
    logic        fault_en;
    logic        fault_val;
    logic        qb_fault;

    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic        err_pulse;
    logic        err_sticky;
    logic [1:0]  state;

    logic [3:0]  sat_pass;
    logic [3:0]  sat_err;
    logic        sat_pulse;
    logic        sat_sticky;
    logic [1:0]  sat_state;

    int tests_run;
    int tests_failed;

    dff_monitor #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .d(d), .q(q), .qb(qb), .mon_en(mon_en), .clr(clr),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .state(state)
    );

    dff_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .d(d), .q(q), .qb(qb), .mon_en(mon_en), .clr(clr),
        .pass_cnt(sat_pass), .err_cnt(sat_err), .err_pulse(sat_pulse),
        .err_sticky(sat_sticky), .state(sat_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of a correctly working observed flip-flop, with fault overrides.
    always @(posedge clk) q_ff <= d;
    assign q  = fault_en ? fault_val : q_ff;
    assign qb = qb_fault ? q : ~q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mon_en = 1'b0; clr = 1'b0; d = 1'b0;
        fault_en = 1'b0; fault_val = 1'b0; qb_fault = 1'b0;
        step(); step();
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state); end
        tests_run++; if (pass_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_pass: got %0d want 0", pass_cnt); end
        tests_run++; if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        tests_run++; if (err_pulse !== 1'b0 || err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got pulse=%0b sticky=%0b want 0 0", err_pulse, err_sticky); end
        tests_run++; if (sat_state !== 2'd0) begin tests_failed++; $display("FAIL reset_sat_state: got %0d want 0", sat_state); end
    endtask

    task automatic test_correct_ff();
        logic pulse_seen;
        pulse_seen = 1'b0;
        rst = 1'b0; mon_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            d = (k % 2 == 0);
            step();
            if (err_pulse) pulse_seen = 1'b1;
            if (k == 2) begin
                tests_run++; if (state !== 2'd2 || pass_cnt !== 16'd0) begin tests_failed++; $display("FAIL arm_latency: got state=%0d pass=%0d want 2 0", state, pass_cnt); end
            end
            if (k == 16) begin
                tests_run++; if (sat_pass !== 4'd14 || sat_state !== 2'd2) begin tests_failed++; $display("FAIL sat_before: got pass=%0d state=%0d want 14 2", sat_pass, sat_state); end
            end
            if (k == 17) begin
                tests_run++; if (sat_pass !== 4'd15 || sat_state !== 2'd3) begin tests_failed++; $display("FAIL sat_reach: got pass=%0d state=%0d want 15 3", sat_pass, sat_state); end
            end
        end
        tests_run++; if (pass_cnt !== 16'd18) begin tests_failed++; $display("FAIL ff_pass: got %0d want 18", pass_cnt); end
        tests_run++; if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL ff_err: got %0d want 0", err_cnt); end
        tests_run++; if (err_sticky !== 1'b0 || pulse_seen !== 1'b0) begin tests_failed++; $display("FAIL ff_flags: got sticky=%0b pulse_seen=%0b want 0 0", err_sticky, pulse_seen); end
        tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL ff_state: got %0d want 2", state); end
        tests_run++; if (sat_pass !== 4'd15 || sat_state !== 2'd3 || sat_err !== 4'd0) begin tests_failed++; $display("FAIL sat_hold: got pass=%0d state=%0d err=%0d want 15 3 0", sat_pass, sat_state, sat_err); end
    endtask

    task automatic test_fault();
        d = 1'b1;
        step();
        tests_run++; if (pass_cnt !== 16'd19) begin tests_failed++; $display("FAIL fault_pre_pass: got %0d want 19", pass_cnt); end
        fault_en = 1'b1; fault_val = 1'b0; d = 1'b0;
        step();
        tests_run++; if (err_cnt !== 16'd1 || pass_cnt !== 16'd19) begin tests_failed++; $display("FAIL fault_cnt: got err=%0d pass=%0d want 1 19", err_cnt, pass_cnt); end
        tests_run++; if (err_pulse !== 1'b1 || err_sticky !== 1'b1) begin tests_failed++; $display("FAIL fault_flags: got pulse=%0b sticky=%0b want 1 1", err_pulse, err_sticky); end
        fault_en = 1'b0;
        step();
        tests_run++; if (err_pulse !== 1'b0 || err_sticky !== 1'b1) begin tests_failed++; $display("FAIL fault_after: got pulse=%0b sticky=%0b want 0 1", err_pulse, err_sticky); end
        tests_run++; if (err_cnt !== 16'd1 || pass_cnt !== 16'd20) begin tests_failed++; $display("FAIL fault_after_cnt: got err=%0d pass=%0d want 1 20", err_cnt, pass_cnt); end
        mon_en = 1'b0;
        step();
        tests_run++; if (state !== 2'd0 || pass_cnt !== 16'd20 || err_cnt !== 16'd1 || err_sticky !== 1'b1) begin tests_failed++; $display("FAIL disable_hold: got state=%0d pass=%0d err=%0d sticky=%0b want 0 20 1 1", state, pass_cnt, err_cnt, err_sticky); end
        tests_run++; if (sat_state !== 2'd3) begin tests_failed++; $display("FAIL sat_ignores_en: got %0d want 3", sat_state); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests_run++; if (pass_cnt !== 16'd0 || err_cnt !== 16'd0 || err_sticky !== 1'b0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL clr_all: got pass=%0d err=%0d sticky=%0b pulse=%0b want 0 0 0 0", pass_cnt, err_cnt, err_sticky, err_pulse); end
        tests_run++; if (sat_state !== 2'd0 || sat_pass !== 4'd0) begin tests_failed++; $display("FAIL sat_clr_exit: got state=%0d pass=%0d want 0 0", sat_state, sat_pass); end
    endtask

    task automatic test_clr_mismatch();
        d = 1'b1; mon_en = 1'b1;
        step(); step(); step();
        tests_run++; if (pass_cnt !== 16'd1 || state !== 2'd2) begin tests_failed++; $display("FAIL clrmis_pre: got pass=%0d state=%0d want 1 2", pass_cnt, state); end
        fault_en = 1'b1; fault_val = 1'b0; clr = 1'b1;
        step();
        tests_run++; if (err_cnt !== 16'd0 || err_sticky !== 1'b0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL clrmis_err: got err=%0d sticky=%0b pulse=%0b want 0 0 0", err_cnt, err_sticky, err_pulse); end
        tests_run++; if (state !== 2'd0 || pass_cnt !== 16'd0) begin tests_failed++; $display("FAIL clrmis_state: got state=%0d pass=%0d want 0 0", state, pass_cnt); end
        clr = 1'b0; fault_en = 1'b0; mon_en = 1'b0;
        step();
        tests_run++; if (err_cnt !== 16'd0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL clrmis_idle: got err=%0d pulse=%0b want 0 0", err_cnt, err_pulse); end
    endtask

    task automatic test_mid_reset();
        mon_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            d = (k % 2 == 0);
            step();
        end
        tests_run++; if (pass_cnt !== 16'd5 || state !== 2'd2) begin tests_failed++; $display("FAIL mrst_pre: got pass=%0d state=%0d want 5 2", pass_cnt, state); end
        fault_en = 1'b1; fault_val = ~d; d = ~d;
        step();
        tests_run++; if (err_cnt !== 16'd1 || err_pulse !== 1'b1 || pass_cnt !== 16'd5) begin tests_failed++; $display("FAIL mrst_fault: got err=%0d pulse=%0b pass=%0d want 1 1 5", err_cnt, err_pulse, pass_cnt); end
        fault_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (state !== 2'd0 || pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin tests_failed++; $display("FAIL mrst_async_cnt: got state=%0d pass=%0d err=%0d want 0 0 0", state, pass_cnt, err_cnt); end
        tests_run++; if (err_pulse !== 1'b0 || err_sticky !== 1'b0) begin tests_failed++; $display("FAIL mrst_async_flags: got pulse=%0b sticky=%0b want 0 0", err_pulse, err_sticky); end
        step();
        rst = 1'b0;
        d = ~d;
        step();
        tests_run++; if (state !== 2'd1 || pass_cnt !== 16'd0) begin tests_failed++; $display("FAIL mrst_arm: got state=%0d pass=%0d want 1 0", state, pass_cnt); end
        d = ~d;
        step();
        tests_run++; if (state !== 2'd2 || pass_cnt !== 16'd0) begin tests_failed++; $display("FAIL mrst_check: got state=%0d pass=%0d want 2 0", state, pass_cnt); end
        d = ~d;
        step();
        tests_run++; if (pass_cnt !== 16'd1 || err_cnt !== 16'd0) begin tests_failed++; $display("FAIL mrst_first_cmp: got pass=%0d err=%0d want 1 0", pass_cnt, err_cnt); end
    endtask

    task automatic test_qb();
        logic [15:0] exp_err;
        logic [15:0] exp_pass;
        logic        exp_pulse;
`ifdef DFF_MON_QB_CHECK_EN
        exp_err = 16'd3; exp_pass = 16'd1; exp_pulse = 1'b1;
`else
        exp_err = 16'd0; exp_pass = 16'd4; exp_pulse = 1'b0;
`endif
        clr = 1'b1;
        step();
        clr = 1'b0; mon_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) qb_fault = 1'b1;
            if (k == 6) qb_fault = 1'b0;
            d = (k % 2 == 0);
            step();
            if (k == 5) begin
                tests_run++; if (err_cnt !== exp_err || err_pulse !== exp_pulse) begin tests_failed++; $display("FAIL qb_during: got err=%0d pulse=%0b want %0d %0b", err_cnt, err_pulse, exp_err, exp_pulse); end
            end
        end
        tests_run++; if (err_cnt !== exp_err || pass_cnt !== exp_pass) begin tests_failed++; $display("FAIL qb_final: got err=%0d pass=%0d want %0d %0d", err_cnt, pass_cnt, exp_err, exp_pass); end
        tests_run++; if (err_pulse !== 1'b0 || err_sticky !== exp_pulse) begin tests_failed++; $display("FAIL qb_flags: got pulse=%0b sticky=%0b want 0 %0b", err_pulse, err_sticky, exp_pulse); end
        mon_en = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        q_ff = 1'b0;
        test_reset();
        test_correct_ff();
        test_fault();
        test_clr_mismatch();
        test_mid_reset();
        test_qb();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dff_monitor.md
DFF_MONITOR -- requirements
Module: dff_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the pass and error counters.
REQ-002 SHALL have port clk  input  1  single clock; all sampling on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port d  input  1  data presented to the observed flip-flop.
REQ-005 SHALL have port q  input  1  observed flip-flop output.
REQ-006 SHALL have port qb  input  1  observed flip-flop complement output.
REQ-007 SHALL have port mon_en  input  1  checking enable, level-sensitive.
REQ-008 SHALL have port clr  input  1  synchronous clear of counters and sticky flag.
REQ-009 SHALL have port pass_cnt  output  CNT_W  number of matching compares.
REQ-010 SHALL have port err_cnt  output  CNT_W  number of mismatching compares.
REQ-011 SHALL have port err_pulse  output  1  one-cycle flag, registered, high for each mismatch.
REQ-012 SHALL have port err_sticky  output  1  set on first mismatch, held until clr or rst.
REQ-013 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-014 SHALL implement the states IDLE=0, ARM=1, CHECK=2 and SAT=3.
REQ-015 SHALL register d into internal exp on every rising edge, regardless of state.
REQ-016 SHALL, in IDLE with mon_en=1, go to ARM; with mon_en=0, stay in IDLE; no compare is made in IDLE.
REQ-017 SHALL, in ARM, make no compare (exp is being primed) and go to CHECK if mon_en=1, otherwise IDLE.
REQ-018 SHALL, in CHECK, compare the sampled q against exp each edge (q at edge k+1 vs d at edge k).
REQ-019 SHALL, on a match, increment pass_cnt.
REQ-020 SHALL, on a mismatch, increment err_cnt, pulse err_pulse at the next cycle and set err_sticky.
REQ-021 SHALL give a compare-to-output latency of one clock: counters and err_pulse update on the same edge as the compare.
REQ-022 SHALL saturate each counter at all-ones with no wrap; when either counter reaches all-ones, the FSM goes to SAT.
REQ-023 SHALL, in SAT, perform no compares and hold the counters; SAT exits only on clr (to IDLE) or rst.
REQ-024 SHALL move CHECK to IDLE when mon_en=0; counters and err_sticky hold.
REQ-025 SHALL, when clr=1 in any state, clear pass_cnt, err_cnt, err_sticky and err_pulse and move to IDLE.
REQ-026 SHALL give clr priority over a simultaneous compare; that compare is discarded.
REQ-027 SHALL drive state continuously from the FSM register.

Reset
REQ-028 SHALL, on rst=1 and immediately (asynchronously), set state=IDLE, pass_cnt=0, err_cnt=0, err_pulse=0, err_sticky=0 and exp=0.
REQ-029 SHALL, on reset asserted mid-CHECK, abandon the in-flight compare with no counter update; after release the FSM re-arms via IDLE then ARM.

Configuration
REQ-030 SHALL, with DFF_MON_QB_CHECK_EN defined, also compare qb against ~q in CHECK; any failing condition (q or qb) counts as exactly one mismatch per cycle.
REQ-031 SHALL, without DFF_MON_QB_CHECK_EN, ignore qb entirely; only q against exp is checked.

Verification
REQ-032 SHALL cover correct flip-flop: rst released, mon_en=1, d toggles 0,1,0,1 for 20 cycles -> err_cnt=0, pass_cnt=18, err_sticky=0.
REQ-033 SHALL cover an injected fault: force q=0 while exp=1 for one cycle -> err_cnt=1, single-cycle err_pulse, err_sticky=1 until clr.
REQ-034 SHALL cover saturation: CNT_W=4, mon_en=1 for 20 cycles with a correct DUT -> pass_cnt=15, state=SAT, no further increments.
REQ-035 SHALL cover clr during a mismatch: clr=1 on the mismatch edge -> err_cnt=0, err_sticky=0, state=IDLE.
REQ-036 SHALL cover mid-run reset: rst pulse in CHECK with pass_cnt=5 -> all outputs 0 at once; after release, 2 cycles (IDLE, ARM) pass before the first compare.
REQ-037 SHALL cover, with DFF_MON_QB_CHECK_EN defined, qb forced equal to q for 3 cycles -> err_cnt=3; without the macro, err_cnt=0.
